pa_lsu_spsram_ctrl_1024x4: RTL and testbench

Access controller that sits directly upstream of the LSU 1024x4 single-port SRAM macro wrapper and drives its A/CEN/GWEN/WEN/D pins. After reset, and on request, it sweeps the whole array to a known value. It then accepts single-beat read and write requests over a valid/ready handshake and returns read data one cycle after a read is accepted. Only one array access is issued per cycle, and CEN is low only on cycles that issue an access.

---
 rtl/pa_lsu_spsram_ctrl_1024x4_pkg.sv | 15 +
 rtl/pa_lsu_spsram_ctrl_1024x4.sv | 128 ++++++++++++
 tb/tb_pa_lsu_spsram_ctrl_1024x4.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pa_lsu_spsram_ctrl_1024x4_pkg.sv
// Shared LSU definitions for the 1024x4 single-port SRAM controller.
// State encodings and default geometry / init value.
package pa_lsu_spsram_ctrl_1024x4_pkg;

    localparam int LSU_ADDR_W = 10;
    localparam int LSU_DATA_W = 4;
    localparam int LSU_WE_W   = 4;

    localparam logic [3:0] LSU_INIT_VAL = 4'b0000;

    localparam logic [1:0] ST_BOOT  = 2'b00;
    localparam logic [1:0] ST_INIT  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

endpackage

// File: rtl/pa_lsu_spsram_ctrl_1024x4.sv
// Access controller for the LSU 1024x4 single-port SRAM macro.
// Sweeps the array after reset/flush, then serves single-beat reads/writes.
module pa_lsu_spsram_ctrl_1024x4
    import pa_lsu_spsram_ctrl_1024x4_pkg::*;
#(
    parameter int ADDR_WIDTH = LSU_ADDR_W,
    parameter int DATA_WIDTH = LSU_DATA_W,
    parameter int WE_WIDTH   = LSU_WE_W,
    parameter int INIT_EN    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL = LSU_INIT_VAL
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  flush_req,
    output logic                  init_done,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [WE_WIDTH-1:0]   req_wen,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [WE_WIDTH-1:0]   WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q
);

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] d_q;

    logic in_init, in_ready, acc, acc_wr, acc_rd, issue;

    assign in_init  = (state_q == ST_INIT);
    assign in_ready = (state_q == ST_READY);
    assign req_rdy  = in_ready & ~flush_req;
    assign acc      = req_vld & req_rdy;
    assign acc_wr   = acc & req_wr;
    assign acc_rd   = acc & ~req_wr;
    assign issue    = in_init | acc;

    assign init_done = in_ready;
    assign rd_vld    = rd_pend_q;
    assign rd_data   = Q;
    assign rd_pend_d = acc_rd;

    // Next state and sweep counter; flush restarts the sweep from 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BOOT: begin
                state_d = (INIT_EN != 0) ? ST_INIT : ST_READY;
                cnt_d   = '0;
            end
            ST_INIT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (flush_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_BOOT;
                cnt_d   = '0;
            end
        endcase
    end

    // SRAM pin mux; idle cycles park A/D on their last driven values.
    always_comb begin
        CEN  = ~issue;
        GWEN = ~(in_init | acc_wr);
        WEN  = '1;
        A    = a_q;
        D    = d_q;
        if (in_init) begin
            WEN = '0;
            A   = cnt_q;
            D   = INIT_VAL;
        end else if (acc) begin
            A = req_addr;
            if (req_wr) begin
                WEN = req_wen;
                D   = req_wdata;
            end
        end
    end

    // FSM, counter and read-pending flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_BOOT;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Last driven address/data, held while the array is idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q <= '0;
            d_q <= '0;
        end else if (issue) begin
            a_q <= A;
            d_q <= D;
        end
    end

endmodule

// File: tb/tb_pa_lsu_spsram_ctrl_1024x4.sv
// Directed bench for pa_lsu_spsram_ctrl_1024x4 with a behavioural
// 1024x4 single-port SRAM hooked to its pins.
module tb_pa_lsu_spsram_ctrl_1024x4;

    logic       CLK, RST, flush_req;
    logic       init_done, req_vld, req_rdy, req_wr;
    logic [9:0] req_addr, A;
    logic [3:0] req_wdata, req_wen, rd_data, WEN, D, Q;
    logic       rd_vld, CEN, GWEN;

    logic [3:0] mem [1024];

    int n_chk;
    int n_fail;

    pa_lsu_spsram_ctrl_1024x4 dut (
        .CLK(CLK), .RST(RST), .flush_req(flush_req),
        .init_done(init_done), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wen(req_wen), .rd_vld(rd_vld), .rd_data(rd_data),
        .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural macro: registered read, per-bit active-low write.
    always @(posedge CLK) begin
        if (!CEN) begin
            if (!GWEN) begin
                for (int b = 0; b < 4; b++)
                    if (!WEN[b]) mem[A][b] <= D[b];
            end else begin
                Q <= mem[A];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [9:0] a,
                         input logic [3:0] wd, input logic [3:0] we,
                         input logic fl);
        @(negedge CLK);
        req_vld   = v;
        req_wr    = w;
        req_addr  = a;
        req_wdata = wd;
        req_wen   = we;
        flush_req = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 10'h0, 4'h0, 4'hF, 1'b0);
    endtask

    // Called just after RST release: one BOOT cycle then a sweep.
    // stop_at < 1024 returns mid-sweep right after checking that address.
    task automatic sweep(input int stop_at);
        chk("boot_cen", CEN, 1);
        chk("boot_done", init_done, 0);
        chk("boot_rdy", req_rdy, 0);
        for (int i = 0; i < 1024; i++) begin
            @(negedge CLK);
            #1;
            chk("sweep_a", A, i);
            chk("sweep_pins", {CEN, GWEN, WEN, D, init_done, req_rdy}, 0);
            if (i == stop_at) return;
        end
        @(negedge CLK);
        #1;
        chk("sweep_done", init_done, 1);
        chk("sweep_idle_cen", CEN, 1);
        chk("sweep_rdy", req_rdy, 1);
    endtask

    initial begin
        int k;
        n_chk     = 0;
        n_fail    = 0;
        RST       = 1'b1;
        flush_req = 1'b0;
        req_vld   = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wen   = 4'hF;
        for (int i = 0; i < 1024; i++) mem[i] = 4'hF;

        #12;
        chk("rst_pins", {CEN, GWEN, WEN, A, D}, {1'b1, 1'b1, 4'hF, 10'h0, 4'h0});
        chk("rst_ctl", {req_rdy, rd_vld, init_done}, 0);

        @(negedge CLK);
        RST = 1'b0;
        #1;
        sweep(2000);
        chk("mem_swept", mem[1023], 0);

        drive(1, 1, 10'h155, 4'hA, 4'h0, 0);
        chk("wr_pins", {CEN, GWEN, WEN, A, D}, {1'b0, 1'b0, 4'h0, 10'h155, 4'hA});
        drive(1, 0, 10'h155, 4'h0, 4'hF, 0);
        chk("rd_pins", {CEN, GWEN, WEN, A}, {1'b0, 1'b1, 4'hF, 10'h155});
        chk("rd_vld_early", rd_vld, 0);
        idle();
        chk("raw_vld", rd_vld, 1);
        chk("raw_data", rd_data, 4'hA);
        chk("idle_pins", {CEN, GWEN, WEN}, {1'b1, 1'b1, 4'hF});
        chk("hold_ad", {A, D}, {10'h155, 4'hA});
        idle();
        chk("vld_pulse", rd_vld, 0);

        drive(1, 1, 10'h155, 4'h3, 4'hC, 0);
        chk("pw_wen", WEN, 4'hC);
        drive(1, 0, 10'h155, 4'h0, 4'hF, 0);
        idle();
        chk("pw_data", {rd_vld, rd_data}, {1'b1, 4'hB});

        drive(1, 1, 10'h001, 4'h6, 4'h0, 0);
        drive(1, 1, 10'h002, 4'h9, 4'h0, 0);
        drive(1, 1, 10'h003, 4'hC, 4'h0, 0);
        drive(1, 0, 10'h001, 4'h0, 4'hF, 0);
        drive(1, 0, 10'h002, 4'h0, 4'hF, 0);
        chk("b2b_0", {rd_vld, rd_data}, {1'b1, 4'h6});
        drive(1, 0, 10'h003, 4'h0, 4'hF, 0);
        chk("b2b_1", {rd_vld, rd_data}, {1'b1, 4'h9});
        idle();
        chk("b2b_2", {rd_vld, rd_data}, {1'b1, 4'hC});
        idle();
        chk("b2b_end", rd_vld, 0);

        drive(1, 1, 10'h155, 4'h0, 4'hF, 0);
        chk("nw_pins", {CEN, GWEN, WEN}, {1'b0, 1'b0, 4'hF});
        drive(1, 0, 10'h155, 4'h0, 4'hF, 0);
        idle();
        chk("nw_data", {rd_vld, rd_data}, {1'b1, 4'hB});

        drive(1, 0, 10'h155, 4'h0, 4'hF, 0);
        drive(1, 0, 10'h002, 4'h0, 4'hF, 1);
        chk("fl_rdy", req_rdy, 0);
        chk("fl_cen", CEN, 1);
        chk("fl_rd", {rd_vld, rd_data}, {1'b1, 4'hB});
        idle();
        chk("fl_init", {A, CEN, init_done}, {10'h0, 1'b0, 1'b0});
        chk("fl_noacc", rd_vld, 0);
        k = 1;
        while (!init_done && k < 1100) begin
            @(negedge CLK);
            #1;
            if (!init_done) k++;
        end
        chk("fl_len", k, 1024);
        drive(1, 0, 10'h155, 4'h0, 4'hF, 0);
        drive(1, 0, 10'h003, 4'h0, 4'hF, 0);
        chk("fl_rd155", {rd_vld, rd_data}, {1'b1, 4'h0});
        idle();
        chk("fl_rd3", {rd_vld, rd_data}, {1'b1, 4'h0});

        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        sweep(500);
        RST = 1'b1;
        #1;
        chk("mid_rst_pins", {CEN, GWEN, WEN, A, D}, {1'b1, 1'b1, 4'hF, 10'h0, 4'h0});
        chk("mid_rst_ctl", {req_rdy, rd_vld, init_done}, 0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        sweep(2000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
